// File: rtl/flash_read_arbiter.sv
// Timed asynchronous read sequencer for an 8-bit parallel NOR flash, shared
// between two requesters with round-robin arbitration. Read-only: no program/erase.
module flash_read_arbiter #(
    parameter int WAIT_CYCLES = 4,   // OE_N low cycles before capture, 1..15
    parameter int ADDR_W      = 23
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_A,
    input  logic              REQ_B,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [ADDR_W-1:0] ADDR_B,
    output logic              ACK_A,
    output logic              ACK_B,
    output logic [7:0]        RDATA,
    output logic              BUSY,
    input  logic [7:0]        FL_DQ,
    input  logic              FL_RY,
    output logic [ADDR_W-1:0] FL_ADDR,
    output logic              FL_CE_N,
    output logic              FL_OE_N,
    output logic              FL_WE_N,
    output logic              FL_RESET_N,
    output logic              FL_WP_N
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWN_A,
        OWN_B
    } owner_t;

    state_t              state_q,  state_d;
    owner_t              ptr_q,    ptr_d;
    owner_t              owner_q,  owner_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [7:0]          rdata_q,  rdata_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                ce_n_q,   ce_n_d;
    logic                oe_n_q,   oe_n_d;
    logic                ack_a_q,  ack_a_d;
    logic                ack_b_q,  ack_b_d;
    logic                busy_q,   busy_d;
    logic                fl_rst_n_q;

    owner_t              winner;

    // Pointer only matters on a tie; a lone requester always wins.
    assign winner = (REQ_A && REQ_B) ? ptr_q : (REQ_A ? OWN_A : OWN_B);

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (FL_RY && (REQ_A || REQ_B)) begin
                    owner_d = winner;
                    ptr_d   = (winner == OWN_A) ? OWN_B : OWN_A;
                    addr_d  = (winner == OWN_A) ? ADDR_A : ADDR_B;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = FL_DQ;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pin levels are decoded from the next state so they register with it.
        ce_n_d  = !((state_d == ST_SETUP) || (state_d == ST_WAIT));
        oe_n_d  = (state_d != ST_WAIT);
        ack_a_d = (state_d == ST_DONE) && (owner_d == OWN_A);
        ack_b_d = (state_d == ST_DONE) && (owner_d == OWN_B);
        busy_d  = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            ptr_q      <= OWN_A;
            owner_q    <= OWN_A;
            addr_q     <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            busy_q     <= 1'b0;
            fl_rst_n_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            busy_q     <= busy_d;
            fl_rst_n_q <= 1'b1;
        end
    end

    assign ACK_A      = ack_a_q;
    assign ACK_B      = ack_b_q;
    assign RDATA      = rdata_q;
    assign BUSY       = busy_q;
    assign FL_ADDR    = addr_q;
    assign FL_CE_N    = ce_n_q;
    assign FL_OE_N    = oe_n_q;
    assign FL_WE_N    = 1'b1;
    assign FL_WP_N    = 1'b1;
    assign FL_RESET_N = fl_rst_n_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: a W=4 and a W=1 instance share all inputs and
// are compared every cycle against a phase-timeline model, plus directed literal checks.
module tb_flash_read_arbiter;

    localparam int AW = 23;
    localparam int W0 = 4;
    localparam int W1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n  = 1'b0;
    logic          req_a  = 1'b0;
    logic          req_b  = 1'b0;
    logic          fl_ry  = 1'b1;
    logic [AW-1:0] addr_a = '0;
    logic [AW-1:0] addr_b = '0;
    logic          cmp_en = 1'b0;

    logic          ack_a [2];
    logic          ack_b [2];
    logic          busy  [2];
    logic          ce_n  [2];
    logic          oe_n  [2];
    logic          we_n  [2];
    logic          wp_n  [2];
    logic          frst  [2];
    logic [7:0]    rdata [2];
    logic [7:0]    dq    [2];
    logic [AW-1:0] fl_addr [2];

    int vectors    = 0;
    int miscompares = 0;

    // Flash contents: a fixed byte function of the address (0x1234 -> 0x5A).
    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h7C;
    endfunction

    // Bus floats to a recognisable junk value unless the chip is selected and output-enabled.
    assign dq[0] = (!ce_n[0] && !oe_n[0]) ? mem_byte(fl_addr[0]) : 8'hEE;
    assign dq[1] = (!ce_n[1] && !oe_n[1]) ? mem_byte(fl_addr[1]) : 8'hEE;

    flash_read_arbiter #(.WAIT_CYCLES(W0), .ADDR_W(AW)) dut0 (
        .CLK(clk), .RESET_N(rst_n), .REQ_A(req_a), .REQ_B(req_b),
        .ADDR_A(addr_a), .ADDR_B(addr_b), .ACK_A(ack_a[0]), .ACK_B(ack_b[0]),
        .RDATA(rdata[0]), .BUSY(busy[0]), .FL_DQ(dq[0]), .FL_RY(fl_ry),
        .FL_ADDR(fl_addr[0]), .FL_CE_N(ce_n[0]), .FL_OE_N(oe_n[0]), .FL_WE_N(we_n[0]),
        .FL_RESET_N(frst[0]), .FL_WP_N(wp_n[0])
    );

    flash_read_arbiter #(.WAIT_CYCLES(W1), .ADDR_W(AW)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .REQ_A(req_a), .REQ_B(req_b),
        .ADDR_A(addr_a), .ADDR_B(addr_b), .ACK_A(ack_a[1]), .ACK_B(ack_b[1]),
        .RDATA(rdata[1]), .BUSY(busy[1]), .FL_DQ(dq[1]), .FL_RY(fl_ry),
        .FL_ADDR(fl_addr[1]), .FL_CE_N(ce_n[1]), .FL_OE_N(oe_n[1]), .FL_WE_N(we_n[1]),
        .FL_RESET_N(frst[1]), .FL_WP_N(wp_n[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: timeline of an access, counted in cycles since the grant edge
    int            m_phase [2];
    logic          m_ptr   [2];   // 0 = A, 1 = B
    logic          m_own   [2];
    logic          m_frst  [2];
    logic [AW-1:0] m_addr  [2];
    logic [7:0]    m_rdata [2];

    function automatic int wcyc(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic logic pick(input logic ra, input logic rb, input logic ptr);
        if (ra && rb) return ptr;
        return rb;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_phase[d] <= 0;
                m_ptr[d]   <= 1'b0;
                m_own[d]   <= 1'b0;
                m_frst[d]  <= 1'b0;
                m_addr[d]  <= '0;
                m_rdata[d] <= '0;
            end else begin
                m_frst[d] <= 1'b1;
                if (m_phase[d] == 0) begin
                    if (fl_ry && (req_a || req_b)) begin
                        m_phase[d] <= 1;
                        m_own[d]   <= pick(req_a, req_b, m_ptr[d]);
                        m_ptr[d]   <= !pick(req_a, req_b, m_ptr[d]);
                        m_addr[d]  <= pick(req_a, req_b, m_ptr[d]) ? addr_b : addr_a;
                    end
                end else if (m_phase[d] == wcyc(d) + 2) begin
                    m_phase[d] <= 0;
                end else begin
                    m_phase[d] <= m_phase[d] + 1;
                    if (m_phase[d] == wcyc(d) + 1)
                        m_rdata[d] <= mem_byte(m_addr[d]);
                end
            end
        end
    end

    function automatic logic [63:0] pack(input logic aa, input logic ab, input logic bz,
                                         input logic ce, input logic oe, input logic we,
                                         input logic wp, input logic rs,
                                         input logic [7:0] rd, input logic [AW-1:0] ad);
        return {25'b0, ad, rd, aa, ab, bz, ce, oe, we, wp, rs};
    endfunction

    // Compare process: all outputs of both instances, every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                int p;
                int w;
                logic [63:0] e;
                logic [63:0] a;
                p = m_phase[d];
                w = wcyc(d);
                e = pack((p == w + 2) && !m_own[d], (p == w + 2) && m_own[d], p != 0,
                         !(p >= 1 && p <= w + 1), !(p >= 2 && p <= w + 1), 1'b1, 1'b1,
                         m_frst[d], m_rdata[d], m_addr[d]);
                a = pack(ack_a[d], ack_b[d], busy[d], ce_n[d], oe_n[d], we_n[d], wp_n[d],
                         frst[d], rdata[d], fl_addr[d]);
                check((d == 0) ? "w4_outputs" : "w1_outputs", a, e);
            end
        end
    end

    // Cycle counters used by the directed checks.
    int ce_lo [2] = '{0, 0};
    int oe_lo [2] = '{0, 0};
    int acka_n[2] = '{0, 0};
    int ackb_n[2] = '{0, 0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ce_n[d] === 1'b0)  ce_lo[d]  <= ce_lo[d] + 1;
            if (oe_n[d] === 1'b0)  oe_lo[d]  <= oe_lo[d] + 1;
            if (ack_a[d] === 1'b1) acka_n[d] <= acka_n[d] + 1;
            if (ack_b[d] === 1'b1) ackb_n[d] <= ackb_n[d] + 1;
        end
    end

    // ---------------- stimulus helpers
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input int d, input logic use_b, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if ((use_b ? ack_b[d] : ack_a[d]) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (busy[0] === 1'b0 && busy[1] === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("idle_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int last;
        int b_ce, b_oe, b_aa, b_ab, b1_ce, b1_oe, b1_aa, b1_ab;

        // Reset state
        repeat (3) step();
        cmp_en = 1'b1;
        check("rst_fl_reset_n", 64'(frst[0]), 64'(0));
        check("rst_ce_n", 64'(ce_n[0]), 64'(1));
        check("rst_rdata", 64'(rdata[0]), 64'(0));
        rst_n = 1'b1;
        step();
        check("fl_reset_n_release", 64'(frst[0]), 64'(1));

        // Single read on A, W=4
        addr_a = 23'h001234;
        b_ce = ce_lo[0]; b_oe = oe_lo[0]; b_aa = acka_n[0]; b_ab = ackb_n[0];
        req_a = 1'b1;
        wait_ack(0, 1'b0, 20, n);
        check("single_latency", 64'(n), 64'(6));
        check("single_rdata", 64'(rdata[0]), 64'h5A);
        check("single_fl_addr", 64'(fl_addr[0]), 64'h001234);
        check("model_rdata_pin", 64'(m_rdata[0]), 64'h5A);
        req_a = 1'b0;
        wait_idle(40);
        check("single_ce_low_cycles", 64'(ce_lo[0] - b_ce), 64'(5));
        check("single_oe_low_cycles", 64'(oe_lo[0] - b_oe), 64'(4));
        check("single_ack_a_count", 64'(acka_n[0] - b_aa), 64'(1));
        check("single_ack_b_count", 64'(ackb_n[0] - b_ab), 64'(0));

        // Both held: grants alternate A,B,A,B every W+3 cycles
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        addr_a = 23'h000010;
        addr_b = 23'h000020;
        req_a = 1'b1;
        req_b = 1'b1;
        k = 0;
        last = 0;
        for (int i = 1; i <= 60 && k < 4; i++) begin
            step();
            if (ack_a[0] === 1'b1 || ack_b[0] === 1'b1) begin
                check("rr_owner", 64'({ack_a[0], ack_b[0]}), (k % 2 == 0) ? 64'b10 : 64'b01);
                check("rr_rdata", 64'(rdata[0]), (k % 2 == 0) ? 64'h6C : 64'h5C);
                if (k == 0) check("rr_first_latency", 64'(i), 64'(6));
                else        check("rr_ack_spacing", 64'(i - last), 64'(7));
                last = i;
                k++;
            end
        end
        check("rr_ack_total", 64'(k), 64'(4));
        req_a = 1'b0;
        req_b = 1'b0;
        wait_idle(40);

        // FL_RY low holds off the access
        fl_ry = 1'b0;
        addr_b = 23'h00ABCD;
        req_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("ry_low_ce_n", 64'(ce_n[0]), 64'(1));
            check("ry_low_busy", 64'(busy[0]), 64'(0));
        end
        fl_ry = 1'b1;
        wait_ack(0, 1'b1, 20, n);
        check("ry_release_latency", 64'(n), 64'(6));
        check("ry_release_rdata", 64'(rdata[0]), 64'h1A);
        req_b = 1'b0;
        wait_idle(40);

        // Reset in the middle of WAIT
        addr_a = 23'h001234;
        b_aa = acka_n[0]; b_ab = ackb_n[0];
        req_a = 1'b1;
        repeat (3) step();
        check("pre_abort_oe_n", 64'(oe_n[0]), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ce_n", 64'(ce_n[0]), 64'(1));
        check("abort_oe_n", 64'(oe_n[0]), 64'(1));
        check("abort_fl_reset_n", 64'(frst[0]), 64'(0));
        check("abort_busy", 64'(busy[0]), 64'(0));
        req_a = 1'b0;
        repeat (2) step();
        check("abort_no_ack", 64'((acka_n[0] - b_aa) + (ackb_n[0] - b_ab)), 64'(0));
        rst_n = 1'b1;
        step();
        addr_b = 23'h000020;
        req_b = 1'b1;
        wait_ack(0, 1'b1, 20, n);
        check("post_abort_latency", 64'(n), 64'(6));
        check("post_abort_rdata", 64'(rdata[0]), 64'h5C);
        req_b = 1'b0;
        wait_idle(40);

        // WAIT_CYCLES=1 instance at the top address
        addr_a = 23'h7FFFFF;
        b1_ce = ce_lo[1]; b1_oe = oe_lo[1]; b1_aa = acka_n[1]; b1_ab = ackb_n[1];
        req_a = 1'b1;
        wait_ack(1, 1'b0, 20, n);
        check("w1_latency", 64'(n), 64'(3));
        check("w1_rdata", 64'(rdata[1]), 64'h03);
        check("w1_fl_addr", 64'(fl_addr[1]), 64'h7FFFFF);
        req_a = 1'b0;
        wait_idle(40);
        check("w1_oe_low_cycles", 64'(oe_lo[1] - b1_oe), 64'(1));
        check("w1_ce_low_cycles", 64'(ce_lo[1] - b1_ce), 64'(2));
        check("w1_ack_count", 64'((acka_n[1] - b1_aa) + (ackb_n[1] - b1_ab)), 64'(1));
        check("w4_top_rdata", 64'(rdata[0]), 64'h03);

        // One-cycle REQ pulse still completes exactly once
        addr_a = 23'h000010;
        b_aa = acka_n[0]; b1_aa = acka_n[1];
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        repeat (15) step();
        check("early_drop_w4_acks", 64'(acka_n[0] - b_aa), 64'(1));
        check("early_drop_w1_acks", 64'(acka_n[1] - b1_aa), 64'(1));
        check("early_drop_w4_rdata", 64'(rdata[0]), 64'h6C);
        check("early_drop_w1_rdata", 64'(rdata[1]), 64'h6C);
        check("early_drop_idle", 64'({busy[0], busy[1]}), 64'(0));

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
